fetch_unit: RTL and testbench

Instruction fetch stage of the 5-stage pipeline, upstream of the IF/ID pipeline wall.
- Owns the PC.
- Issues single-outstanding requests on the instruction-memory handshake.
- Buffers returned words in a small FIFO so fetch continues while decode is stalled.
- Presents the head instruction and its PC to the IF/ID register.
- Honours stall (do_hazard) and branch redirect. Redirect discards stale in-flight responses.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: fetch FSM states, FIFO entry layout and PC helpers.
package cpu_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSN_NOP         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // One buffered fetch: the word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetched {pc, instruction} pairs with flush.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // Next-state for pointers and occupancy; flush wins over everything.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; occupancy gates every read, so stale contents are never seen.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding memory request at a
// time, buffers returned words and hands the head instruction to IF/ID.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  input  logic        do_hazard,
  input  logic        do_redirect,
  input  logic [31:0] iRedirect_pc,
  output logic        oFetch_valid,
  output logic [31:0] oFetch_instruction,
  output logic [31:0] oFetch_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_addr_q, pend_addr_d;
  logic [31:0]   last_pc_q, last_pc_d;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_wdata, fifo_head;
  logic          xfer;

  // Request depends only on registered state. Reset forces it low at once so an
  // empty FIFO held in reset does not present a request.
  always_comb begin
    im_req  = 1'b0;
    im_addr = fetch_pc_q;
    if (!reset) begin
      if (state_q == DISCARD) begin
        im_req  = 1'b1;
        im_addr = pend_addr_q;
      end else begin
        im_req  = (fifo_count < DEPTH_C);
        im_addr = fetch_pc_q;
      end
    end
  end

  assign xfer       = im_req & im_ack;
  assign fifo_wdata = '{pc: fetch_pc_q, insn: im_rdata};

  // Fetch control: redirect beats stall and ack; a response to a stale request is dropped.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pend_addr_d = pend_addr_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    if (do_redirect) begin
      fifo_flush = 1'b1;
      fetch_pc_d = align_pc(iRedirect_pc);
      if (state_q == RUN) begin
        // Request cannot be withdrawn: remember its address and wait out the ack.
        if (im_req && !im_ack) begin
          state_d     = DISCARD;
          pend_addr_d = fetch_pc_q;
        end
      end else if (im_ack) begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      fifo_pop = ~fifo_empty & ~do_hazard;
      if (xfer && (!fifo_full || fifo_pop)) begin
        fifo_push  = 1'b1;
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
    end else if (im_ack) begin
      state_d = RUN;
    end
  end

  // The head PC is remembered so the PC output holds steady across bubbles.
  always_comb begin
    last_pc_d = fifo_empty ? last_pc_q : fifo_head.pc;
  end

  // Fetch state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      pend_addr_q <= RESET_PC;
      last_pc_q   <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pend_addr_q <= pend_addr_d;
      last_pc_q   <= last_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign oFetch_valid       = ~fifo_empty;
  assign oFetch_instruction = fifo_empty ? INSN_NOP : fifo_head.insn;
  assign oFetch_pc          = fifo_empty ? last_pc_q : fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns addr + 0x100 for every word.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        do_hazard;
  logic        do_redirect;
  logic [31:0] iRedirect_pc;
  logic        oFetch_valid;
  logic [31:0] oFetch_instruction;
  logic [31:0] oFetch_pc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .im_req             (im_req),
    .im_addr            (im_addr),
    .im_ack             (im_ack),
    .im_rdata           (im_rdata),
    .do_hazard          (do_hazard),
    .do_redirect        (do_redirect),
    .iRedirect_pc       (iRedirect_pc),
    .oFetch_valid       (oFetch_valid),
    .oFetch_instruction (oFetch_instruction),
    .oFetch_pc          (oFetch_pc)
  );

  assign im_rdata = im_addr + 32'h100;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] insn);
    check({tag, ".valid"}, {31'b0, oFetch_valid}, {31'b0, v});
    check({tag, ".pc"}, oFetch_pc, pc);
    check({tag, ".insn"}, oFetch_instruction, insn);
  endtask

  task automatic check_req(input string tag, input logic r, input logic [31:0] a);
    check({tag, ".im_req"}, {31'b0, im_req}, {31'b0, r});
    check({tag, ".im_addr"}, im_addr, a);
  endtask

  initial begin
    reset        = 1'b1;
    im_ack       = 1'b0;
    do_hazard    = 1'b0;
    do_redirect  = 1'b0;
    iRedirect_pc = 32'h0;

    // Reset values
    #2;
    check_out("rst", 1'b0, 32'h0, 32'h0);
    check_req("rst", 1'b0, 32'h0);

    // Streaming with ack tied high
    @(negedge clock);
    reset  = 1'b0;
    im_ack = 1'b1;
    #1;
    check_req("c0", 1'b1, 32'h0);
    check_out("c0", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("c1", 1'b1, 32'h0, 32'h100);
    check_req("c1", 1'b1, 32'h4);
    tick();
    check_out("c2", 1'b1, 32'h4, 32'h104);
    tick();
    check_out("c3", 1'b1, 32'h8, 32'h108);
    check_req("c3", 1'b1, 32'hC);

    // Stall for four edges: FIFO fills, request drops, head frozen
    do_hazard = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stall", 1'b1, 32'h8, 32'h108);
      check("stall.im_req", {31'b0, im_req}, 32'h0);
    end
    do_hazard = 1'b0;
    #1;
    check("rel.pc", oFetch_pc, 32'h8);
    tick();
    check_out("rel1", 1'b1, 32'hC, 32'h10C);
    check_req("rel1", 1'b1, 32'h10);
    tick();
    check_out("rel2", 1'b1, 32'h10, 32'h110);
    tick();
    check_out("rel3", 1'b1, 32'h14, 32'h114);

    // Redirect with ack in the same cycle: response dropped, PC output holds
    do_redirect  = 1'b1;
    iRedirect_pc = 32'h10;
    tick();
    check_out("rd0", 1'b0, 32'h14, 32'h0);
    check_req("rd0", 1'b1, 32'h10);

    // Slow memory: redirect to 0x203 while the 0x10 request is pending
    do_redirect = 1'b0;
    im_ack      = 1'b0;
    tick();
    check_req("slow1", 1'b1, 32'h10);
    do_redirect  = 1'b1;
    iRedirect_pc = 32'h203;
    tick();
    check_req("slow2", 1'b1, 32'h10);
    do_redirect = 1'b0;
    tick();
    check_req("slow3", 1'b1, 32'h10);
    check("slow3.valid", {31'b0, oFetch_valid}, 32'h0);
    im_ack = 1'b1;
    tick();
    check_req("disc_ack", 1'b1, 32'h200);
    check("disc_ack.valid", {31'b0, oFetch_valid}, 32'h0);
    tick();
    check_out("newpc", 1'b1, 32'h200, 32'h300);
    check_req("newpc", 1'b1, 32'h204);

    // Redirect to 0x40 while the 0x20 word is being acked
    do_redirect  = 1'b1;
    iRedirect_pc = 32'h20;
    tick();
    check_req("r20", 1'b1, 32'h20);
    iRedirect_pc = 32'h40;
    tick();
    check_out("r40", 1'b0, 32'h200, 32'h0);
    check_req("r40", 1'b1, 32'h40);
    do_redirect = 1'b0;
    tick();
    check_out("r40b", 1'b1, 32'h40, 32'h140);

    // Address wrap at the top of memory; low target bits are ignored
    do_redirect  = 1'b1;
    iRedirect_pc = 32'hFFFF_FFFF;
    tick();
    check_req("wrap0", 1'b1, 32'hFFFF_FFFC);
    do_redirect = 1'b0;
    tick();
    check_out("wrap1", 1'b1, 32'hFFFF_FFFC, 32'h0000_00FC);
    check_req("wrap1", 1'b1, 32'h0);
    tick();
    check_out("wrap2", 1'b1, 32'h0, 32'h100);

    // Reset in the middle of DISCARD
    im_ack       = 1'b0;
    do_redirect  = 1'b1;
    iRedirect_pc = 32'h80;
    tick();
    check_req("dsc1", 1'b1, 32'h4);
    check("dsc1.valid", {31'b0, oFetch_valid}, 32'h0);
    iRedirect_pc = 32'h90;
    tick();
    check_req("dsc2", 1'b1, 32'h4);
    do_redirect = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_out("mrst", 1'b0, 32'h0, 32'h0);
    check_req("mrst", 1'b0, 32'h0);
    @(negedge clock);
    reset  = 1'b0;
    im_ack = 1'b1;
    #1;
    check_req("mrst_rel", 1'b1, 32'h0);
    tick();
    check_out("mrst_run", 1'b1, 32'h0, 32'h100);
    check_req("mrst_run", 1'b1, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
